// File: rtl/ahb_dw_splitter_if.sv
// Bus bundle for the 64-to-32 bit AHB-Lite size converter.
// Upstream (64-bit) and downstream (32-bit) signals share one interface.
interface ahb_dw_splitter_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic        HREADY;
    logic [63:0] HWDATA;
    logic [63:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] M_HADDR;
    logic [1:0]  M_HTRANS;
    logic [2:0]  M_HSIZE;
    logic        M_HWRITE;
    logic [31:0] M_HWDATA;
    logic [31:0] M_HRDATA;
    logic        M_HREADY;
    logic        M_HRESP;

    modport slave (
        input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HREADY, HWDATA,
               M_HRDATA, M_HREADY, M_HRESP,
        output HRDATA, HREADYOUT, HRESP,
               M_HADDR, M_HTRANS, M_HSIZE, M_HWRITE, M_HWDATA
    );

    modport master (
        output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HREADY, HWDATA,
               M_HRDATA, M_HREADY, M_HRESP,
        input  HRDATA, HREADYOUT, HRESP,
               M_HADDR, M_HTRANS, M_HSIZE, M_HWRITE, M_HWDATA
    );
endinterface

// File: rtl/ahb_dw_splitter.sv
// AHB-Lite 64-to-32 bit size converter: splits aligned doubleword transfers into
// two 32-bit transfers, passes narrower transfers straight through.
module ahb_dw_splitter (
    input  logic               HCLK,
    input  logic               HRESETn,
    ahb_dw_splitter_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SGL   = 3'd1,
        ST_DW_LO = 3'd2,
        ST_DW_HI = 3'd3,
        ST_ERR1  = 3'd4,
        ST_ERR2  = 3'd5
    } state_t;

    state_t       state_q, state_d;
    logic         a2_q, a2_d;
    logic         wr_q, wr_d;
    logic [31:3]  addr_q, addr_d;
    logic [31:0]  lo_q, lo_d;

    logic         accept_s;
    logic         dw_s;
    logic         misalign_s;
    state_t       new_state_s;
    logic         passthru_s;

    // Request decode and the state a completing data phase hands over to
    always_comb begin
        accept_s   = bus.HSEL & ((bus.HTRANS == 2'b10) | (bus.HTRANS == 2'b11)) & bus.HREADY;
        dw_s       = (bus.HSIZE == 3'd3);
        misalign_s = dw_s & (bus.HADDR[2:0] != 3'd0);
        if (!accept_s) begin
            new_state_s = ST_IDLE;
        end else if (misalign_s) begin
            new_state_s = ST_ERR1;
        end else if (dw_s) begin
            new_state_s = ST_DW_LO;
        end else begin
            new_state_s = ST_SGL;
        end
    end

    // Next-state and capture logic
    always_comb begin
        state_d = state_q;
        a2_d    = a2_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                state_d = new_state_s;
            end
            ST_SGL, ST_DW_HI: begin
                if (bus.M_HREADY) begin
                    state_d = new_state_s;
                end else begin
                    state_d = state_q;
                end
            end
            ST_DW_LO: begin
                // A low-half error abandons the high half and behaves like pass-through
                if (bus.M_HRESP) begin
                    if (bus.M_HREADY) begin
                        state_d = new_state_s;
                    end else begin
                        state_d = state_q;
                    end
                end else if (bus.M_HREADY) begin
                    state_d = ST_DW_HI;
                    lo_d    = bus.M_HRDATA;
                end else begin
                    state_d = state_q;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (accept_s) begin
            a2_d   = bus.HADDR[2];
            wr_d   = bus.HWRITE;
            addr_d = bus.HADDR[31:3];
        end else begin
            a2_d   = a2_q;
            wr_d   = wr_q;
            addr_d = addr_q;
        end
    end

    // State and capture registers
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            a2_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= 29'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            a2_q    <= a2_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            lo_q    <= lo_d;
        end
    end

    // Downstream address-phase mux and upstream response; reset forces a quiet bus
    always_comb begin
        passthru_s = (state_q == ST_IDLE) || (state_q == ST_SGL) || (state_q == ST_DW_HI) ||
                     (state_q == ST_ERR2) || ((state_q == ST_DW_LO) && bus.M_HRESP);

        if (passthru_s) begin
            bus.M_HADDR  = bus.HADDR;
            bus.M_HWRITE = bus.HWRITE;
            bus.M_HSIZE  = (bus.HSIZE > 3'd2) ? 3'd2 : bus.HSIZE;
            bus.M_HTRANS = (accept_s && !misalign_s) ? 2'b10 : 2'b00;
        end else if (state_q == ST_DW_LO) begin
            bus.M_HADDR  = {addr_q, 3'b100};
            bus.M_HWRITE = wr_q;
            bus.M_HSIZE  = 3'd2;
            bus.M_HTRANS = 2'b10;
        end else begin
            bus.M_HADDR  = {addr_q, 3'b000};
            bus.M_HWRITE = wr_q;
            bus.M_HSIZE  = 3'd2;
            bus.M_HTRANS = 2'b00;
        end

        case (state_q)
            ST_SGL: begin
                bus.M_HWDATA  = a2_q ? bus.HWDATA[63:32] : bus.HWDATA[31:0];
                bus.HRDATA    = a2_q ? {bus.M_HRDATA, 32'h0000_0000} : {32'h0000_0000, bus.M_HRDATA};
                bus.HREADYOUT = bus.M_HREADY;
                bus.HRESP     = bus.M_HRESP;
            end
            ST_DW_LO: begin
                bus.M_HWDATA  = bus.HWDATA[31:0];
                bus.HRDATA    = {bus.M_HRDATA, lo_q};
                bus.HREADYOUT = bus.M_HRESP ? bus.M_HREADY : 1'b0;
                bus.HRESP     = bus.M_HRESP;
            end
            ST_DW_HI: begin
                bus.M_HWDATA  = bus.HWDATA[63:32];
                bus.HRDATA    = {bus.M_HRDATA, lo_q};
                bus.HREADYOUT = bus.M_HREADY;
                bus.HRESP     = bus.M_HRESP;
            end
            ST_ERR1: begin
                bus.M_HWDATA  = bus.HWDATA[31:0];
                bus.HRDATA    = {bus.M_HRDATA, lo_q};
                bus.HREADYOUT = 1'b0;
                bus.HRESP     = 1'b1;
            end
            ST_ERR2: begin
                bus.M_HWDATA  = bus.HWDATA[31:0];
                bus.HRDATA    = {bus.M_HRDATA, lo_q};
                bus.HREADYOUT = 1'b1;
                bus.HRESP     = 1'b1;
            end
            default: begin
                bus.M_HWDATA  = bus.HWDATA[31:0];
                bus.HRDATA    = {bus.M_HRDATA, lo_q};
                bus.HREADYOUT = 1'b1;
                bus.HRESP     = 1'b0;
            end
        endcase

        if (!HRESETn) begin
            bus.M_HTRANS  = 2'b00;
            bus.HREADYOUT = 1'b1;
            bus.HRESP     = 1'b0;
        end else begin
            bus.M_HTRANS  = bus.M_HTRANS;
            bus.HREADYOUT = bus.HREADYOUT;
            bus.HRESP     = bus.HRESP;
        end
    end

endmodule

// File: tb/tb_ahb_dw_splitter.sv
// Directed bench for ahb_dw_splitter: single, doubleword, misaligned, error and reset cases.
module tb_ahb_dw_splitter;

    logic HCLK;
    logic HRESETn;
    int   tests;
    int   fails;

    ahb_dw_splitter_if bus ();

    ahb_dw_splitter dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    // Single subordinate on the bus: upstream HREADY follows our own HREADYOUT
    assign bus.HREADY = bus.HREADYOUT;

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic req(input logic [31:0] addr, input logic [2:0] size, input logic wr);
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HADDR  = addr;
        bus.HSIZE  = size;
        bus.HWRITE = wr;
    endtask

    task automatic noreq();
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        HRESETn      = 1'b0;
        bus.HSEL     = 1'b0;
        bus.HADDR    = 32'h0;
        bus.HTRANS   = 2'b00;
        bus.HSIZE    = 3'd0;
        bus.HWRITE   = 1'b0;
        bus.HWDATA   = 64'h0;
        bus.M_HRDATA = 32'h0;
        bus.M_HREADY = 1'b1;
        bus.M_HRESP  = 1'b0;

        // Reset: an active request must not reach the downstream bus
        tick();
        req(32'h0000_0010, 3'd2, 1'b0);
        #4;
        chk("rst_htrans", {62'd0, bus.M_HTRANS}, 64'd0);
        chk("rst_hreadyout", {63'd0, bus.HREADYOUT}, 64'd1);
        chk("rst_hresp", {63'd0, bus.HRESP}, 64'd0);
        noreq();
        tick();
        HRESETn = 1'b1;
        tick();

        // Single read at 0x4, lands in the upper lanes
        req(32'h0000_0004, 3'd2, 1'b0);
        #4;
        chk("sgl_maddr", {32'd0, bus.M_HADDR}, 64'h4);
        chk("sgl_mtrans", {62'd0, bus.M_HTRANS}, 64'h2);
        chk("sgl_msize", {61'd0, bus.M_HSIZE}, 64'h2);
        tick();
        noreq();
        bus.M_HRDATA = 32'hDEAD_BEEF;
        #4;
        chk("sgl_hrdata", bus.HRDATA, 64'hDEAD_BEEF_0000_0000);
        chk("sgl_hready", {63'd0, bus.HREADYOUT}, 64'd1);
        chk("sgl_hresp", {63'd0, bus.HRESP}, 64'd0);
        tick();

        // Doubleword write at 0x100
        req(32'h0000_0100, 3'd3, 1'b1);
        #4;
        chk("dww_maddr0", {32'd0, bus.M_HADDR}, 64'h100);
        chk("dww_mtrans0", {62'd0, bus.M_HTRANS}, 64'h2);
        chk("dww_msize0", {61'd0, bus.M_HSIZE}, 64'h2);
        chk("dww_mwrite0", {63'd0, bus.M_HWRITE}, 64'd1);
        tick();
        noreq();
        bus.HWDATA = 64'h1122_3344_5566_7788;
        #4;
        chk("dww_mwdata0", {32'd0, bus.M_HWDATA}, 64'h5566_7788);
        chk("dww_maddr1", {32'd0, bus.M_HADDR}, 64'h104);
        chk("dww_mtrans1", {62'd0, bus.M_HTRANS}, 64'h2);
        chk("dww_mwrite1", {63'd0, bus.M_HWRITE}, 64'd1);
        chk("dww_hready0", {63'd0, bus.HREADYOUT}, 64'd0);
        tick();
        #4;
        chk("dww_mwdata1", {32'd0, bus.M_HWDATA}, 64'h1122_3344);
        chk("dww_hready1", {63'd0, bus.HREADYOUT}, 64'd1);
        chk("dww_mtrans_idle", {62'd0, bus.M_HTRANS}, 64'h0);
        tick();

        // Doubleword read at 0x200, one wait on the high half, then pipelined single write
        req(32'h0000_0200, 3'd3, 1'b0);
        tick();
        noreq();
        bus.M_HRDATA = 32'hAAAA_0000;
        #4;
        chk("dwr_maddr1", {32'd0, bus.M_HADDR}, 64'h204);
        chk("dwr_mwrite1", {63'd0, bus.M_HWRITE}, 64'd0);
        chk("dwr_hready0", {63'd0, bus.HREADYOUT}, 64'd0);
        tick();
        bus.M_HREADY = 1'b0;
        bus.M_HRDATA = 32'h5555_5555;
        #4;
        chk("dwr_hready_wait", {63'd0, bus.HREADYOUT}, 64'd0);
        tick();
        bus.M_HREADY = 1'b1;
        bus.M_HRDATA = 32'h0000_BBBB;
        req(32'h0000_000C, 3'd2, 1'b1);
        #4;
        chk("dwr_hrdata", bus.HRDATA, 64'h0000_BBBB_AAAA_0000);
        chk("dwr_hready1", {63'd0, bus.HREADYOUT}, 64'd1);
        chk("b2b_mtrans", {62'd0, bus.M_HTRANS}, 64'h2);
        chk("b2b_maddr", {32'd0, bus.M_HADDR}, 64'hC);
        tick();
        noreq();
        bus.HWDATA = 64'hCAFE_F00D_1234_5678;
        #4;
        chk("b2b_mwdata", {32'd0, bus.M_HWDATA}, 64'hCAFE_F00D);
        chk("b2b_hready", {63'd0, bus.HREADYOUT}, 64'd1);
        tick();

        // Misaligned doubleword at 0x204
        req(32'h0000_0204, 3'd3, 1'b0);
        #4;
        chk("mis_mtrans0", {62'd0, bus.M_HTRANS}, 64'h0);
        tick();
        noreq();
        #4;
        chk("mis_hresp0", {63'd0, bus.HRESP}, 64'd1);
        chk("mis_hready0", {63'd0, bus.HREADYOUT}, 64'd0);
        chk("mis_mtrans1", {62'd0, bus.M_HTRANS}, 64'h0);
        tick();
        #4;
        chk("mis_hresp1", {63'd0, bus.HRESP}, 64'd1);
        chk("mis_hready1", {63'd0, bus.HREADYOUT}, 64'd1);
        tick();
        #4;
        chk("mis_hresp_clr", {63'd0, bus.HRESP}, 64'd0);
        tick();

        // Downstream error on the low half cancels the high half
        req(32'h0000_0300, 3'd3, 1'b0);
        tick();
        noreq();
        bus.M_HRESP  = 1'b1;
        bus.M_HREADY = 1'b0;
        #4;
        chk("lerr_mtrans", {62'd0, bus.M_HTRANS}, 64'h0);
        chk("lerr_hresp0", {63'd0, bus.HRESP}, 64'd1);
        chk("lerr_hready0", {63'd0, bus.HREADYOUT}, 64'd0);
        tick();
        bus.M_HREADY = 1'b1;
        #4;
        chk("lerr_hresp1", {63'd0, bus.HRESP}, 64'd1);
        chk("lerr_hready1", {63'd0, bus.HREADYOUT}, 64'd1);
        chk("lerr_mtrans1", {62'd0, bus.M_HTRANS}, 64'h0);
        tick();
        bus.M_HRESP = 1'b0;
        #4;
        chk("lerr_idle_hresp", {63'd0, bus.HRESP}, 64'd0);
        tick();

        // Reset asserted while stalled in the high half
        req(32'h0000_0400, 3'd3, 1'b1);
        tick();
        noreq();
        tick();
        bus.M_HREADY = 1'b0;
        #1;
        chk("hi_stall_hready", {63'd0, bus.HREADYOUT}, 64'd0);
        HRESETn = 1'b0;
        req(32'h0000_0500, 3'd2, 1'b0);
        #3;
        chk("rstm_hready", {63'd0, bus.HREADYOUT}, 64'd1);
        chk("rstm_hresp", {63'd0, bus.HRESP}, 64'd0);
        chk("rstm_mtrans", {62'd0, bus.M_HTRANS}, 64'h0);
        tick();
        noreq();
        HRESETn = 1'b1;
        #4;
        chk("rstm_idle_hready", {63'd0, bus.HREADYOUT}, 64'd1);
        chk("rstm_idle_mtrans", {62'd0, bus.M_HTRANS}, 64'h0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ahb_dw_splitter.md
# ahb_dw_splitter

AHB-Lite size converter between the 64-bit system bus and a 32-bit subordinate. It splits each aligned doubleword transfer (HSIZE=3) into two back-to-back 32-bit transfers and inserts one wait state. Transfers of HSIZE ≤ 2 pass through with zero added wait states. It steers the 32-bit data onto the correct half of the 64-bit lanes and returns a local ERROR for misaligned doubleword requests.

## Interface
No parameters.
- HCLK  in  1  bus clock; all state on rising edge
- HRESETn  in  1  asynchronous active-low reset
- HSEL  in  1  upstream subordinate select
- HADDR  in  32  upstream address
- HTRANS  in  2  upstream transfer type (bit 1 = active)
- HSIZE  in  3  upstream size; 3 = doubleword
- HWRITE  in  1  upstream write
- HREADY  in  1  upstream bus ready; transfer accepted when HSEL & HTRANS[1] & HREADY
- HWDATA  in  64  upstream write data
- HRDATA  out  64  upstream read data
- HREADYOUT  out  1  upstream ready
- HRESP  out  1  upstream error response
- M_HADDR  out  32  downstream address
- M_HTRANS  out  2  downstream type, only IDLE (00) or NONSEQ (10)
- M_HSIZE  out  3  downstream size, never > 2
- M_HWRITE  out  1  downstream write
- M_HWDATA  out  32  downstream write data
- M_HRDATA  in  32  downstream read data
- M_HREADY  in  1  downstream ready
- M_HRESP  in  1  downstream error

## Operation
- States: IDLE, SGL, DW_LO, DW_HI, ERR1, ERR2. Reset → IDLE; all registers 0.
- Pass-through states are IDLE, SGL, DW_HI and ERR2. In these:
  - M_HADDR = HADDR, M_HWRITE = HWRITE, M_HSIZE = min(HSIZE,2).
  - M_HTRANS = NONSEQ if accepted, else IDLE.
  - Exception: an accepted HSIZE=3 with HADDR[2:0]≠0 drives M_HTRANS=IDLE.
- A data phase completes in:
  - IDLE and ERR2: always.
  - SGL and DW_HI: when M_HREADY=1.
- On completion, the next state is set by the new request:
  - no accept → IDLE
  - HSIZE≤2 → SGL
  - aligned HSIZE=3 → DW_LO
  - misaligned HSIZE=3 → ERR1
- On every accept, capture A2=HADDR[2], HWRITE, and HADDR[31:3].
- SGL (single transfer):
  - HREADYOUT=M_HREADY, HRESP=M_HRESP.
  - M_HWDATA = A2 ? HWDATA[63:32] : HWDATA[31:0].
  - HRDATA = A2 ? {M_HRDATA,32'h0} : {32'h0,M_HRDATA}.
- DW_LO (low half of a doubleword):
  - M_HWDATA = HWDATA[31:0].
  - Downstream address phase drives {addr[31:3],3'b100}, NONSEQ, size 2, captured HWRITE.
  - HREADYOUT=0, HRESP=0.
  - When M_HREADY=1 and M_HRESP=0: latch M_HRDATA into LO; go to DW_HI.
- DW_LO error path (M_HRESP=1):
  - Downstream address mux switches to pass-through, which cancels the high transfer and forwards any pending upstream request.
  - HRESP=1, HREADYOUT=M_HREADY.
  - On the completion cycle (M_HREADY=1), apply the pass-through next-state rule.
- DW_HI (high half):
  - M_HWDATA = HWDATA[63:32].
  - HRDATA = {M_HRDATA, LO}.
  - HREADYOUT=M_HREADY, HRESP=M_HRESP.
- ERR1: M_HTRANS=IDLE, HREADYOUT=0, HRESP=1. Go to ERR2.
- ERR2: HREADYOUT=1, HRESP=1.
- Outside SGL/DW_HI, HRDATA is driven from LO and M_HRDATA per the DW_HI mapping; contents are don't-care.
- While HRESETn=0: M_HTRANS=IDLE, HREADYOUT=1, HRESP=0.
- Reset asserted mid-transfer aborts to IDLE. No downstream transfer is re-issued.

## Timing
- Single transfer: adds zero wait states. The downstream address phase is in the same cycle as upstream acceptance.
- Doubleword transfer, zero-wait subordinate:
  - Upstream data phase lasts 2 cycles (1 wait state).
  - Low address phase coincides with acceptance; high address phase occurs in the first data cycle.
- Downstream wait states add 1:1 to either half.
- Misaligned doubleword: 2-cycle ERROR; the downstream bus sees no access.
- Back-to-back transfers: a new request accepted in the final DW_HI/SGL cycle is issued downstream in that same cycle (pipelined).
- HWDATA must be held through both DW halves. AHB guarantees this because HREADYOUT is low.

## Test plan
- Single read at 0x0000_0004 with HSIZE=2, M_HRDATA=0xDEADBEEF → HRDATA=0xDEADBEEF_00000000, HREADYOUT=1 with no wait; M_HADDR=0x4.
- Doubleword write at 0x100, HWDATA=0x11223344_55667788 → M_HADDR=0x100 then 0x104; M_HWDATA=0x55667788 then 0x11223344; HREADYOUT=0,1.
- Doubleword read at 0x200, M_HRDATA=0xAAAA0000 then 0x0000BBBB, with 1 downstream wait on the high half → HRDATA=0x0000BBBB_AAAA0000 after 3 data cycles.
- HSIZE=3 at 0x204 → M_HTRANS stays IDLE; HRESP=1 for 2 cycles, HREADYOUT=0 then 1.
- DW_LO with downstream ERROR (M_HRESP=1, M_HREADY=0 then 1) → M_HTRANS becomes IDLE on the first error cycle, so no 0x...4 access occurs; upstream sees HRESP=1 for 2 cycles.
- Reset asserted in DW_HI → state returns to IDLE immediately; HREADYOUT=1, HRESP=0, M_HTRANS=IDLE.
